// File: rtl/asyn_fifo.sv
// -----------------------------------------------------------------------------
// asyn_fifo
// This is a single-clock FIFO. All state is updated on the rising edge of clk_wr.
// The name and the clk_rd port are kept so that existing instantiations still connect.
//
// Ports
//   clk_wr     : sole clock of the block
//   rst        : synchronous active-low reset, sampled on rising clk_wr
//   clk_rd     : kept for port compatibility; it is not used
//   en_wr/Din  : write request and write data
//   en_rd/Dout : read request and registered read data (one-clock latency)
//   empty/full : combinational occupancy flags, derived from the pointers
//   head_bin/tail_bin   : binary write/read pointers, ADDR_WIDTH+1 bits (debug)
//   head_gray/tail_gray : Gray-coded copies of those pointers (debug)
// -----------------------------------------------------------------------------
module asyn_fifo #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk_wr,
   input  logic                  rst,
   input  logic                  clk_rd,
   input  logic                  en_wr,
   input  logic                  en_rd,
   input  logic [DATA_WIDTH-1:0] Din,
   output logic [DATA_WIDTH-1:0] Dout,
   output logic                  empty,
   output logic                  full,
   output logic [ADDR_WIDTH:0]   head_bin,
   output logic [ADDR_WIDTH:0]   tail_bin,
   output logic [ADDR_WIDTH:0]   head_gray,
   output logic [ADDR_WIDTH:0]   tail_gray
);

   localparam int              DEPTH   = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [ADDR_WIDTH:0]   r_head;
   logic [ADDR_WIDTH:0]   r_tail;
   logic [DATA_WIDTH-1:0] r_dout;
   logic                  w_wr_ok;
   logic                  w_rd_ok;
   logic                  w_unused_clk_rd;

   assign w_unused_clk_rd = clk_rd;

   // The extra pointer MSB separates "wrapped once" from "same lap".
   // That lets equal low bits mean either empty or full.
   assign empty = (r_head == r_tail);
   assign full  = (r_head[ADDR_WIDTH] != r_tail[ADDR_WIDTH]) &&
                  (r_head[ADDR_WIDTH-1:0] == r_tail[ADDR_WIDTH-1:0]);

   // Acceptance uses the flags from before the edge.
   // A write to an empty FIFO cannot be read in the same cycle.
   // A read from a full FIFO does not free a slot for a write in the same cycle.
   assign w_wr_ok = en_wr & ~full;
   assign w_rd_ok = en_rd & ~empty;

   always_ff @(posedge clk_wr) begin
      if (!rst) begin
         r_head <= '0;
         r_tail <= '0;
         r_dout <= '0;
      end else begin
         if (w_wr_ok) r_head <= r_head + PTR_ONE;
         if (w_rd_ok) begin
            r_dout <= r_mem[r_tail[ADDR_WIDTH-1:0]];
            r_tail <= r_tail + PTR_ONE;
         end
      end
   end

   // Storage is not reset. Its contents only become visible through
   // pointer-qualified reads, so stale data from before a reset is never seen.
   always_ff @(posedge clk_wr) begin
      if (rst && w_wr_ok) r_mem[r_head[ADDR_WIDTH-1:0]] <= Din;
   end

   assign Dout      = r_dout;
   assign head_bin  = r_head;
   assign tail_bin  = r_tail;
   assign head_gray = r_head ^ (r_head >> 1);
   assign tail_gray = r_tail ^ (r_tail >> 1);

endmodule

// File: tb/tb_asyn_fifo.sv
module tb_asyn_fifo;

   localparam int AW = 4;
   localparam int DW = 8;
   localparam int DEPTH = 16;

   logic          clk_wr = 1'b0, clk_rd = 1'b0;
   logic          rst, en_wr, en_rd;
   logic [DW-1:0] Din, Dout;
   logic          empty, full;
   logic [AW:0]   head_bin, tail_bin, head_gray, tail_gray;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: a queue of stored words plus pointer counters kept as
   // plain integers modulo 32.
   logic [DW-1:0] q[$];
   logic [DW-1:0] m_dout;
   int            m_head, m_tail;

   always #5 clk_wr = ~clk_wr;
   always #3.5 clk_rd = ~clk_rd;

   asyn_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk_wr(clk_wr), .rst(rst), .clk_rd(clk_rd), .en_wr(en_wr), .en_rd(en_rd),
      .Din(Din), .Dout(Dout), .empty(empty), .full(full),
      .head_bin(head_bin), .tail_bin(tail_bin),
      .head_gray(head_gray), .tail_gray(tail_gray));

   // Drives one cycle from a falling edge and advances the model at the rising edge.
   // It returns at the next falling edge, where the DUT outputs are stable.
   task automatic cycle(input logic r, input logic w, input logic rd, input logic [DW-1:0] d);
      logic pre_full, pre_empty;
      rst = r; en_wr = w; en_rd = rd; Din = d;
      @(posedge clk_wr);
      if (!r) begin
         q.delete(); m_dout = '0; m_head = 0; m_tail = 0;
      end else begin
         pre_full  = (q.size() == DEPTH);
         pre_empty = (q.size() == 0);
         if (rd && !pre_empty) begin
            m_dout = q.pop_front();
            m_tail = (m_tail + 1) % 32;
         end
         if (w && !pre_full) begin
            q.push_back(d);
            m_head = (m_head + 1) % 32;
         end
      end
      @(negedge clk_wr);
   endtask

   task automatic test_reset;
      cycle(1'b0, 1'b1, 1'b1, 8'hA5);
      n_checks++;
      if ({head_bin, tail_bin, Dout, empty, full, head_gray, tail_gray} !== {5'd0, 5'd0, 8'd0, 1'b1, 1'b0, 5'd0, 5'd0}) begin
         n_fail++;
         $display("FAIL reset: head=%0d tail=%0d dout=%h empty=%b full=%b hg=%0d tg=%0d, want all 0 with empty=1",
                  head_bin, tail_bin, Dout, empty, full, head_gray, tail_gray);
      end
      cycle(1'b1, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic test_fill_drain(input logic [DW-1:0] pat, input int exp_head);
      for (int i = 1; i <= DEPTH; i++) begin
         cycle(1'b1, 1'b1, 1'b0, pat);
         n_checks++;
         if (full !== (i == DEPTH)) begin
            n_fail++;
            $display("FAIL fill_full after %0d writes: full=%b want %b", i, full, (i == DEPTH));
         end
      end
      n_checks++;
      if (head_bin !== 5'(exp_head) || empty !== 1'b0) begin
         n_fail++;
         $display("FAIL fill_ptr: head=%0d empty=%b want head=%0d empty=0", head_bin, empty, exp_head);
      end
      // A write while full must be ignored.
      cycle(1'b1, 1'b1, 1'b0, ~pat);
      n_checks++;
      if (head_bin !== 5'(exp_head) || full !== 1'b1) begin
         n_fail++;
         $display("FAIL write_while_full: head=%0d full=%b want head=%0d full=1", head_bin, full, exp_head);
      end
      for (int i = 1; i <= DEPTH; i++) begin
         cycle(1'b1, 1'b0, 1'b1, 8'h00);
         n_checks++;
         if (Dout !== pat || empty !== (i == DEPTH)) begin
            n_fail++;
            $display("FAIL drain read %0d: dout=%h empty=%b want dout=%h empty=%b", i, Dout, empty, pat, (i == DEPTH));
         end
      end
      n_checks++;
      if (tail_bin !== 5'(exp_head)) begin
         n_fail++;
         $display("FAIL drain_ptr: tail=%0d want %0d", tail_bin, exp_head);
      end
      // A read while empty must leave Dout and the tail pointer unchanged.
      cycle(1'b1, 1'b0, 1'b1, 8'h00);
      n_checks++;
      if (Dout !== pat || tail_bin !== 5'(exp_head) || empty !== 1'b1) begin
         n_fail++;
         $display("FAIL read_while_empty: dout=%h tail=%0d empty=%b want %h %0d 1", Dout, tail_bin, empty, pat, exp_head);
      end
   endtask

   task automatic test_back_to_back;
      cycle(1'b0, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, 8'($urandom));
      for (int i = 0; i < 12; i++) begin
         cycle(1'b1, 1'b1, 1'b1, 8'($urandom));
         n_checks++;
         if (5'(head_bin - tail_bin) !== 5'd5 || Dout !== m_dout ||
             head_gray !== (head_bin ^ (head_bin >> 1)) || tail_gray !== (tail_bin ^ (tail_bin >> 1))) begin
            n_fail++;
            $display("FAIL back_to_back %0d: occ=%0d dout=%h hg=%0d tg=%0d want occ=5 dout=%h",
                     i, 5'(head_bin - tail_bin), Dout, head_gray, tail_gray, m_dout);
         end
      end
   endtask

   task automatic test_reset_mid_fill;
      cycle(1'b0, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 7; i++) cycle(1'b1, 1'b1, 1'b0, 8'(8'h30 + i));
      cycle(1'b1, 1'b0, 1'b1, 8'h00);
      cycle(1'b0, 1'b1, 1'b1, 8'h77);
      n_checks++;
      if ({empty, full, head_bin, tail_bin, Dout} !== {1'b1, 1'b0, 5'd0, 5'd0, 8'd0}) begin
         n_fail++;
         $display("FAIL reset_mid_fill: empty=%b full=%b head=%0d tail=%0d dout=%h want 1 0 0 0 00",
                  empty, full, head_bin, tail_bin, Dout);
      end
   endtask

   task automatic test_random;
      logic [DW-1:0] g;
      for (int i = 0; i < 400; i++) begin
         cycle(($urandom_range(0, 59) != 0), ($urandom_range(0, 99) < 55),
               ($urandom_range(0, 99) < 50), 8'($urandom));
         n_checks++;
         if (Dout !== m_dout || empty !== (q.size() == 0) || full !== (q.size() == DEPTH) ||
             head_bin !== 5'(m_head) || tail_bin !== 5'(m_tail) ||
             head_gray !== (5'(m_head) ^ (5'(m_head) >> 1)) || tail_gray !== (5'(m_tail) ^ (5'(m_tail) >> 1))) begin
            n_fail++;
            $display("FAIL random %0d: dout=%h empty=%b full=%b head=%0d tail=%0d hg=%0d tg=%0d want dout=%h occ=%0d head=%0d tail=%0d",
                     i, Dout, empty, full, head_bin, tail_bin, head_gray, tail_gray, m_dout, q.size(), m_head, m_tail);
         end
      end
      // Drain what is left and confirm FIFO order to the end.
      while (q.size() != 0) begin
         g = q[0];
         cycle(1'b1, 1'b0, 1'b1, 8'h00);
         n_checks++;
         if (Dout !== g) begin
            n_fail++;
            $display("FAIL random_drain: dout=%h want %h", Dout, g);
         end
      end
   endtask

   initial begin
      rst = 1'b0; en_wr = 1'b0; en_rd = 1'b0; Din = '0;
      m_dout = '0; m_head = 0; m_tail = 0;
      @(negedge clk_wr);
      test_reset();
      test_fill_drain(8'h00, 16);
      test_fill_drain(8'hFF, 0);
      test_back_to_back();
      test_reset_mid_fill();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
